// File: rtl/bin_to_bcd8.sv
// bin_to_bcd8: sequential shift-and-add-3 converter, 32-bit binary to eight packed BCD digits
module bin_to_bcd8 #(
  parameter bit SATURATE = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [31:0] bin_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] bcd_out,
  output logic        overflow
);
  typedef enum logic {S_IDLE, S_CONV} state_t;
  state_t      r_state;
  logic [31:0] r_bin_sr;
  logic [39:0] r_acc;
  logic [5:0]  r_iter;
  logic [39:0] w_adj;
  logic [71:0] w_shift;
  logic        w_ovf;
  for (genvar d = 0; d < 10; d++) begin : g_dig
    assign w_adj[4*d +: 4] = (r_acc[4*d +: 4] >= 4'd5) ? r_acc[4*d +: 4] + 4'd3 : r_acc[4*d +: 4];
  end
  assign w_shift = {w_adj, r_bin_sr} << 1;
  assign w_ovf   = |w_shift[71:64];
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_bin_sr <= '0;
      r_acc    <= '0;
      r_iter   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd_out  <= '0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      if (r_state == S_IDLE) begin
        if (start) begin
          r_state  <= S_CONV;
          r_bin_sr <= bin_in;
          r_acc    <= '0;
          r_iter   <= '0;
          busy     <= 1'b1;
        end
      end else begin
        r_acc    <= w_shift[71:32];
        r_bin_sr <= w_shift[31:0];
        r_iter   <= r_iter + 6'd1;
        if (r_iter == 6'd31) begin
          r_state  <= S_IDLE;
          busy     <= 1'b0;
          done     <= 1'b1;
          overflow <= w_ovf;
          bcd_out  <= (w_ovf && SATURATE) ? 32'h9999_9999 : w_shift[63:32];
        end
      end
    end
  end
endmodule

// File: tb/tb_bin_to_bcd8.sv
// tb_bin_to_bcd8: vector table, randomized model comparison and multi-cycle corner sequences for both SATURATE settings
module tb_bin_to_bcd8;
  logic        clk = 1'b0, resetn = 1'b0, start = 1'b0;
  logic [31:0] bin_in = '0;
  logic        busy_s, done_s, ovf_s, busy_w, done_w, ovf_w;
  logic [31:0] bcd_s, bcd_w;
  int          errors = 0, checks = 0;

  always #5 clk = ~clk;

  bin_to_bcd8 #(.SATURATE(1'b1)) u_sat (
    .clk(clk), .resetn(resetn), .start(start), .bin_in(bin_in),
    .busy(busy_s), .done(done_s), .bcd_out(bcd_s), .overflow(ovf_s));
  bin_to_bcd8 #(.SATURATE(1'b0)) u_wrap (
    .clk(clk), .resetn(resetn), .start(start), .bin_in(bin_in),
    .busy(busy_w), .done(done_w), .bcd_out(bcd_w), .overflow(ovf_w));

  typedef struct {
    logic [31:0] v;
    logic [31:0] e_sat;
    logic [31:0] e_wrap;
    logic        e_ovf;
  } vec_t;

  // Reference: decimal digits by plain division, saturating when asked
  function automatic logic [32:0] model(input logic [31:0] v, input bit sat);
    logic [31:0]     b;
    longint unsigned m;
    bit              o;
    b = '0;
    m = longint'(v) % 100000000;
    o = v > 32'd99999999;
    if (o && sat) return {1'b1, 32'h9999_9999};
    for (int i = 0; i < 8; i++) begin
      b[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return {o, b};
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  // Called at a negedge; returns at the negedge where done is seen (dk = samples after accept edge)
  task automatic conv(input logic [31:0] v, output int dk, output int bn);
    start  = 1'b1;
    bin_in = v;
    dk = -1;
    bn = 0;
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    bin_in = $urandom;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge clk);
      if (busy_s) bn++;
      if (done_s) begin
        dk = k;
        break;
      end
    end
  endtask

  task automatic check_model(input string n, input logic [31:0] v);
    logic [32:0] ms, mw;
    ms = model(v, 1'b1);
    mw = model(v, 1'b0);
    chk({n, "_bcd_sat"}, bcd_s, ms[31:0]);
    chk({n, "_ovf_sat"}, {31'd0, ovf_s}, {31'd0, ms[32]});
    chk({n, "_bcd_wrap"}, bcd_w, mw[31:0]);
    chk({n, "_ovf_wrap"}, {31'd0, ovf_w}, {31'd0, mw[32]});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        tab[5];
    int          dk, bn, nd, t;
    logic [31:0] v;
    tab[0] = '{32'd0,          32'h0000_0000, 32'h0000_0000, 1'b0};
    tab[1] = '{32'd12345678,   32'h1234_5678, 32'h1234_5678, 1'b0};
    tab[2] = '{32'd99999999,   32'h9999_9999, 32'h9999_9999, 1'b0};
    tab[3] = '{32'd100000000,  32'h9999_9999, 32'h0000_0000, 1'b1};
    tab[4] = '{32'hFFFF_FFFF,  32'h9999_9999, 32'h9467_295 << 4 | 32'h5, 1'b1};
    tab[4].e_wrap = 32'h9496_7295;

    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy_s | busy_w}, 32'd0);
    chk("rst_done", {31'd0, done_s | done_w}, 32'd0);
    chk("rst_bcd", bcd_s | bcd_w, 32'd0);
    chk("rst_ovf", {31'd0, ovf_s | ovf_w}, 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      conv(tab[i].v, dk, bn);
      chk("tab_done_lat", dk, 32);
      chk("tab_busy_len", bn, 32);
      chk("tab_bcd_sat", bcd_s, tab[i].e_sat);
      chk("tab_bcd_wrap", bcd_w, tab[i].e_wrap);
      chk("tab_ovf_sat", {31'd0, ovf_s}, {31'd0, tab[i].e_ovf});
      chk("tab_ovf_wrap", {31'd0, ovf_w}, {31'd0, tab[i].e_ovf});
      @(negedge clk);
      chk("tab_done_pulse", {31'd0, done_s}, 32'd0);
    end

    for (int i = 0; i < 24; i++) begin
      v = (i % 2 == 1) ? $urandom : $urandom_range(0, 99999999);
      conv(v, dk, bn);
      chk("rnd_done_lat", dk, 32);
      check_model("rnd", v);
      @(negedge clk);
    end

    // start pulsed mid-conversion must be ignored
    start = 1'b1;
    bin_in = 32'd42;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    nd = 0;
    for (int k = 1; k <= 44; k++) begin
      @(negedge clk);
      start = (k == 10);
      bin_in = (k == 10) ? 32'd7 : 32'd42;
      if (done_s) nd++;
    end
    start = 1'b0;
    chk("ign_done_cnt", nd, 1);
    chk("ign_bcd", bcd_s, 32'h0000_0042);

    // start during the done cycle is accepted
    conv(32'd42, dk, bn);
    chk("b2b_first", bcd_s, 32'h0000_0042);
    start = 1'b1;
    bin_in = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    t = 1;
    while (!done_s && t < 45) begin
      @(negedge clk);
      t++;
    end
    chk("b2b_spacing", t, 33);
    chk("b2b_bcd", bcd_s, 32'h0000_0007);
    @(negedge clk);

    // reset aborts a conversion
    conv(32'd1234, dk, bn);
    chk("pre_rst_bcd", bcd_s, 32'h0000_1234);
    @(negedge clk);
    start = 1'b1;
    bin_in = 32'd5678;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy_s}, 32'd0);
    chk("abort_bcd", bcd_s, 32'd0);
    chk("abort_ovf", {31'd0, ovf_s}, 32'd0);
    resetn = 1'b1;
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_s) nd++;
    end
    chk("abort_no_done", nd, 0);
    conv(32'd5678, dk, bn);
    chk("after_abort_bcd", bcd_s, 32'h0000_5678);
    @(negedge clk);

    // start held through reset release is accepted on the first active edge
    resetn = 1'b0;
    start = 1'b1;
    bin_in = 32'd99;
    @(negedge clk);
    resetn = 1'b1;
    conv(32'd99, dk, bn);
    chk("rst_start_lat", dk, 32);
    chk("rst_start_bcd", bcd_s, 32'h0000_0099);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
